// File: rtl/rapid_pkg.sv
// Shared types and constants for the rapid core memory path: cache port
// encodings, arbiter state/grant enums and the funct3 access-size codes.
package rapid_pkg;

    localparam int WORD_WIDTH = 4;

    typedef enum logic {
        CACHE_READ  = 1'b0,
        CACHE_WRITE = 1'b1
    } cache_rw_t;

    typedef enum logic [1:0] {
        CACHE_NOP,
        QUARTER_WORD,
        HALF_WORD,
        WORD
    } cache_operation_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_IF_BUSY,
        ARB_MEM_BUSY,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        GRANT_IF,
        GRANT_MEM
    } arb_grant_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic cache_operation_t f3_to_op(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return QUARTER_WORD;
            F3_H, F3_HU: return HALF_WORD;
            default:     return WORD;
        endcase
    endfunction

endpackage

// File: rtl/rapid_load_align.sv
// Picks the addressed byte/half out of an aligned word and sign- or
// zero-extends it according to the load funct3.
module rapid_load_align
    import rapid_pkg::*;
#(
    parameter int DATA_W = WORD_WIDTH * 8
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        data     = rdata;
        case (funct3)
            F3_B:    data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            F3_BU:   data = {{(DATA_W-8){1'b0}}, byte_sel};
            F3_H:    data = {{(DATA_W-16){half_sel[15]}}, half_sel};
            F3_HU:   data = {{(DATA_W-16){1'b0}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/rapid_mem_arbiter.sv
// Shares the single cache port between instruction fetch and load/store,
// one request/response transaction at a time, round-robin on ties.
module rapid_mem_arbiter
    import rapid_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = WORD_WIDTH * 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_ack,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  mem_req,
    input  cache_rw_t             mem_rw,
    input  logic [2:0]            mem_funct3,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_ack,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_fault,
    output logic                  cache_req,
    output cache_rw_t             cache_rw,
    output cache_operation_t      cache_op,
    output logic [ADDR_W-1:0]     cache_addr,
    output logic [DATA_W-1:0]     cache_wdata,
    input  logic [DATA_W-1:0]     cache_rdata,
    input  logic                  cache_done
);

    arb_state_t       state, state_n;
    arb_grant_t       last_grant, grant_q;
    logic             fault_q;
    logic [ADDR_W-1:0] addr_q;
    cache_rw_t        rw_q;
    cache_operation_t op_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]       f3_q;

    logic             grant_if, grant_mem, mem_illegal, busy;
    logic [DATA_W-1:0] store_lanes, load_data;

    // On a tie the port that did not win last time goes first.
    assign grant_if  = if_req  && (!mem_req || last_grant == GRANT_MEM);
    assign grant_mem = mem_req && (!if_req  || last_grant == GRANT_IF);

    always_comb begin
        mem_illegal = 1'b0;
        case (mem_funct3)
            F3_B:    mem_illegal = 1'b0;
            F3_H:    mem_illegal = mem_addr[0];
            F3_W:    mem_illegal = |mem_addr[1:0];
            F3_BU:   mem_illegal = (mem_rw == CACHE_WRITE);
            F3_HU:   mem_illegal = (mem_rw == CACHE_WRITE) || mem_addr[0];
            default: mem_illegal = 1'b1;
        endcase
    end

    always_comb begin
        store_lanes = mem_wdata;
        case (mem_funct3)
            F3_B:    store_lanes = {(DATA_W/8){mem_wdata[7:0]}};
            F3_H:    store_lanes = {(DATA_W/16){mem_wdata[15:0]}};
            default: store_lanes = mem_wdata;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            ARB_IDLE: begin
                if (grant_if)
                    state_n = ARB_IF_BUSY;
                else if (grant_mem)
                    state_n = mem_illegal ? ARB_RESP : ARB_MEM_BUSY;
            end
            ARB_IF_BUSY, ARB_MEM_BUSY: if (cache_done) state_n = ARB_RESP;
            ARB_RESP: state_n = ARB_IDLE;
            default:  state_n = ARB_IDLE;
        endcase
    end

    rapid_load_align #(.DATA_W(DATA_W)) u_load_align (
        .funct3 (f3_q),
        .addr   (addr_q[1:0]),
        .rdata  (cache_rdata),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_grant <= GRANT_IF;
            grant_q    <= GRANT_IF;
            fault_q    <= 1'b0;
            addr_q     <= '0;
            rw_q       <= CACHE_READ;
            op_q       <= CACHE_NOP;
            wdata_q    <= '0;
            f3_q       <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            state <= state_n;
            if (state == ARB_IDLE && grant_if) begin
                last_grant <= GRANT_IF;
                grant_q    <= GRANT_IF;
                fault_q    <= 1'b0;
                addr_q     <= if_addr & ~ADDR_W'(3);
                rw_q       <= CACHE_READ;
                op_q       <= WORD;
                wdata_q    <= '0;
                f3_q       <= F3_W;
            end else if (state == ARB_IDLE && grant_mem) begin
                last_grant <= GRANT_MEM;
                grant_q    <= GRANT_MEM;
                fault_q    <= mem_illegal;
                addr_q     <= mem_addr;
                rw_q       <= mem_rw;
                op_q       <= f3_to_op(mem_funct3);
                wdata_q    <= store_lanes;
                f3_q       <= mem_funct3;
                if (mem_illegal) mem_rdata <= '0;
            end
            if (state == ARB_IF_BUSY && cache_done)
                if_rdata <= cache_rdata;
            // Stores report zero data so the pipeline never sees stale loads.
            if (state == ARB_MEM_BUSY && cache_done)
                mem_rdata <= (rw_q == CACHE_READ) ? load_data : '0;
        end
    end

    assign busy        = (state == ARB_IF_BUSY) || (state == ARB_MEM_BUSY);
    assign cache_req   = busy;
    assign cache_op    = busy ? op_q : CACHE_NOP;
    assign cache_rw    = rw_q;
    assign cache_addr  = addr_q;
    assign cache_wdata = wdata_q;
    assign if_ack      = (state == ARB_RESP) && (grant_q == GRANT_IF);
    assign mem_ack     = (state == ARB_RESP) && (grant_q == GRANT_MEM);
    assign mem_fault   = mem_ack && fault_q;

endmodule

// File: tb/tb_rapid_mem_arbiter.sv
// Scoreboard bench for rapid_mem_arbiter: drivers push expected requests,
// a cache model serves them, and a monitor checks every ack.
module tb_rapid_mem_arbiter;
    import rapid_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             if_req, if_ack, mem_req, mem_ack, mem_fault;
    logic [31:0]      if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
    cache_rw_t        mem_rw, cache_rw;
    logic [2:0]       mem_funct3;
    logic             cache_req, cache_done;
    cache_operation_t cache_op;
    logic [31:0]      cache_addr, cache_wdata, cache_rdata;

    always #5 clk = ~clk;

    rapid_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_fault(mem_fault),
        .cache_req(cache_req), .cache_rw(cache_rw), .cache_op(cache_op),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata),
        .cache_rdata(cache_rdata), .cache_done(cache_done)
    );

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic        fault;
    } req_t;

    typedef struct {
        logic [31:0]      addr;
        cache_operation_t op;
        cache_rw_t        rw;
        logic [31:0]      wdata;
        logic [31:0]      rdata;
    } srv_t;

    req_t  if_q[$], mem_q[$];
    srv_t  srv_q[$];
    srv_t  last_srv, mon_s;
    req_t  mon_e;
    int    ack_order[$];
    int    checks = 0, errors = 0;
    int    creq_cnt = 0;
    int    lat_mode = -1;
    bit    cache_en = 0, force_rd = 0, inject_done = 0;
    logic [31:0] force_val = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference rules, expressed as sizes and arithmetic.
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_fault(input logic rw, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = rw ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        return (a % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int n;
        logic [31:0] v, mask;
        n = size_of(f3);
        if (n == 4) return rd;
        mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (rd >> (8 * a[1:0])) & mask;
        if (!f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] model_lanes(input logic [2:0] f3, input logic [31:0] w);
        case (size_of(f3))
            1:       return {24'h0, w[7:0]} * 32'h0101_0101;
            2:       return {16'h0, w[15:0]} * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic cache_operation_t model_op(input logic [2:0] f3);
        case (size_of(f3))
            1:       return QUARTER_WORD;
            2:       return HALF_WORD;
            default: return WORD;
        endcase
    endfunction

    // Cache model: answers cache_req after lat_mode cycles (random if negative).
    initial begin
        bit in_txn;
        int cnt;
        srv_t s;
        in_txn = 0;
        cnt = 0;
        cache_done = 0;
        cache_rdata = '0;
        forever begin
            @(posedge clk); #1;
            cache_done = inject_done;
            if (!cache_en || !cache_req) in_txn = 0;
            else begin
                if (!in_txn) begin
                    in_txn = 1;
                    cnt = (lat_mode >= 0) ? lat_mode : int'($urandom_range(0, 3));
                end
                if (cnt == 0) begin
                    cache_done  = 1;
                    cache_rdata = force_rd ? force_val : $urandom;
                    s = '{cache_addr, cache_op, cache_rw, cache_wdata, cache_rdata};
                    srv_q.push_back(s);
                    in_txn = 0;
                end else cnt--;
            end
        end
    end

    // Monitor: pops the scoreboard whenever an ack appears.
    always @(negedge clk) begin
        if (cache_req) creq_cnt++;
        if (if_ack) begin
            ack_order.push_back(0);
            if (if_q.size() == 0 || srv_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL if_spurious_ack actual=1 required=0");
            end else begin
                mon_e = if_q.pop_front();
                mon_s = srv_q.pop_front();
                last_srv = mon_s;
                chk("if_cache_addr", mon_s.addr, mon_e.addr & ~32'h3);
                chk("if_cache_op", 32'(mon_s.op), 32'(WORD));
                chk("if_cache_rw", 32'(mon_s.rw), 32'(CACHE_READ));
                chk("if_rdata", if_rdata, mon_s.rdata);
            end
        end
        if (mem_ack) begin
            ack_order.push_back(1);
            if (mem_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_spurious_ack actual=1 required=0");
            end else begin
                mon_e = mem_q.pop_front();
                chk("mem_fault", 32'(mem_fault), 32'(mon_e.fault));
                if (mon_e.fault) chk("mem_fault_rdata", mem_rdata, 32'h0);
                else if (srv_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_no_cache_txn actual=0 required=1");
                end else begin
                    mon_s = srv_q.pop_front();
                    last_srv = mon_s;
                    chk("mem_cache_addr", mon_s.addr, mon_e.addr);
                    chk("mem_cache_op", 32'(mon_s.op), 32'(model_op(mon_e.f3)));
                    chk("mem_cache_rw", 32'(mon_s.rw), 32'(mon_e.rw));
                    if (mon_e.rw) begin
                        chk("mem_store_lanes", mon_s.wdata, model_lanes(mon_e.f3, mon_e.wdata));
                        chk("mem_store_rdata", mem_rdata, 32'h0);
                    end else
                        chk("mem_load_data", mem_rdata, model_load(mon_e.f3, mon_e.addr, mon_s.rdata));
                end
            end
        end
    end

    // Request tasks: raise req now, hold until ack, drop it the cycle after.
    task automatic if_issue(input logic [31:0] a, output int lat);
        req_t e;
        bit got;
        e = '{a, 1'b0, F3_W, 32'h0, 1'b0};
        if_q.push_back(e);
        if_req = 1; if_addr = a; lat = 0; got = 0;
        while (!got && lat <= 200) begin
            @(negedge clk);
            got = if_ack;
            if (!got) lat++;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL if_timeout actual=%0d required<=200", lat);
            void'(if_q.pop_back());
        end
        @(posedge clk); #1;
        if_req = 0;
    endtask

    task automatic mem_issue(input logic rw, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output int lat);
        req_t e;
        bit got;
        e = '{a, rw, f3, wd, is_fault(rw, f3, a)};
        mem_q.push_back(e);
        mem_req = 1; mem_rw = cache_rw_t'(rw); mem_funct3 = f3; mem_addr = a; mem_wdata = wd;
        lat = 0; got = 0;
        while (!got && lat <= 200) begin
            @(negedge clk);
            got = mem_ack;
            if (!got) lat++;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL mem_timeout actual=%0d required<=200", lat);
            void'(mem_q.pop_back());
        end
        @(posedge clk); #1;
        mem_req = 0;
    endtask

    task automatic pulse_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    initial begin
        int lat, c0;
        reset = 1; if_req = 0; if_addr = '0; mem_req = 0; mem_rw = CACHE_READ;
        mem_funct3 = '0; mem_addr = '0; mem_wdata = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_if_ack", 32'(if_ack), 32'h0);
        chk("rst_mem_ack", 32'(mem_ack), 32'h0);
        chk("rst_mem_fault", 32'(mem_fault), 32'h0);
        chk("rst_cache_req", 32'(cache_req), 32'h0);
        chk("rst_cache_op", 32'(cache_op), 32'(CACHE_NOP));
        chk("rst_cache_addr", cache_addr, 32'h0);
        chk("rst_cache_wdata", cache_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        reset = 0;
        cache_en = 1;

        // Fetch timing: done in cycle 2 gives ack in cycle 3.
        lat_mode = 1;
        if_issue(32'h0000_0103, lat);
        chk("if_latency", lat, 3);
        chk("if_addr_forced", last_srv.addr, 32'h0000_0100);

        // Ties after reset alternate, MEM first.
        pulse_reset();
        lat_mode = -1;
        ack_order.delete();
        fork
            begin
                int l;
                repeat (3) if_issue($urandom, l);
            end
            begin
                int l;
                repeat (3) mem_issue(1'b0, F3_W, $urandom & ~32'h3, 32'h0, l);
            end
        join
        chk("tie_count", ack_order.size(), 6);
        for (int i = 0; i < 6 && i < ack_order.size(); i++)
            chk($sformatf("tie_order_%0d", i), ack_order[i], (i % 2 == 0) ? 1 : 0);

        // Load extraction.
        lat_mode = 0; force_rd = 1;
        force_val = 32'h0080_0000;
        mem_issue(1'b0, F3_B, 32'h0000_1002, 32'h0, lat);
        chk("lb_sext", mem_rdata, 32'hFFFF_FF80);
        mem_issue(1'b0, F3_BU, 32'h0000_1002, 32'h0, lat);
        chk("lbu_zext", mem_rdata, 32'h0000_0080);
        force_val = 32'h8001_0000;
        mem_issue(1'b0, F3_HU, 32'h0000_1002, 32'h0, lat);
        chk("lhu_zext", mem_rdata, 32'h0000_8001);
        mem_issue(1'b0, F3_H, 32'h0000_1002, 32'h0, lat);
        chk("lh_sext", mem_rdata, 32'hFFFF_8001);
        force_rd = 0;

        // Store byte replication.
        mem_issue(1'b1, F3_B, 32'h0000_2001, 32'h1234_56AB, lat);
        chk("sb_lanes", last_srv.wdata, 32'hABAB_ABAB);
        chk("sb_op", 32'(last_srv.op), 32'(QUARTER_WORD));
        chk("sb_rw", 32'(last_srv.rw), 32'(CACHE_WRITE));

        // Faults never reach the cache and ack in cycle 1.
        c0 = creq_cnt;
        mem_issue(1'b0, F3_W, 32'h0000_1006, 32'h0, lat);
        chk("lw_misalign_latency", lat, 1);
        chk("lw_misalign_rdata", mem_rdata, 32'h0);
        mem_issue(1'b0, 3'b011, 32'h0000_1000, 32'h0, lat);
        chk("bad_f3_latency", lat, 1);
        chk("fault_no_cache_req", creq_cnt - c0, 0);

        // Reset during a MEM transaction abandons it; a late done is ignored.
        cache_en = 0;
        mem_req = 1; mem_rw = CACHE_READ; mem_funct3 = F3_W; mem_addr = 32'h40;
        lat = 0;
        while (!cache_req && lat < 10) begin @(negedge clk); lat++; end
        chk("busy_reached", 32'(cache_req), 32'h1);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0; mem_req = 0;
        @(negedge clk);
        chk("midrst_cache_req", 32'(cache_req), 32'h0);
        chk("midrst_cache_op", 32'(cache_op), 32'(CACHE_NOP));
        chk("midrst_mem_ack", 32'(mem_ack), 32'h0);
        inject_done = 1;
        @(negedge clk);
        inject_done = 0;
        c0 = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_ack || if_ack || cache_req) c0++;
        end
        chk("late_done_ignored", c0, 0);
        cache_en = 1;
        @(posedge clk); #1;

        // Randomized mixed traffic.
        lat_mode = -1;
        fork
            begin
                int l, g;
                repeat (30) begin
                    if_issue($urandom, l);
                    g = $urandom_range(0, 3);
                    if (g > 0) begin repeat (g) @(posedge clk); #1; end
                end
            end
            begin
                int l, g;
                repeat (30) begin
                    mem_issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                              $urandom & 32'hFFFF, $urandom, l);
                    g = $urandom_range(0, 3);
                    if (g > 0) begin repeat (g) @(posedge clk); #1; end
                end
            end
        join
        repeat (3) @(negedge clk);
        chk("if_queue_drained", if_q.size(), 0);
        chk("mem_queue_drained", mem_q.size(), 0);
        chk("srv_queue_drained", srv_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rapid_mem_arbiter.md
# rapid_mem_arbiter

Arbitrates the single cache port between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences each access as one request/response transaction on the cache.
- Breaks IF/MEM ties round-robin.
- Aligns and extends load data, replicates store data into lanes, and rejects misaligned or illegal MEM accesses without touching the cache.

## Interface
- One clock; reset is synchronous and active-high.
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: word width. Fixed at `WORD_WIDTH`*8; other values are unsupported.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request; held with `if_addr` until `if_ack`.
- `if_addr` in ADDR_W: fetch address; bits [1:0] are ignored and forced to 0.
- `if_ack` out 1: one-cycle response pulse.
- `if_rdata` out DATA_W: instruction word, valid with `if_ack`.
- `mem_req` in 1: load/store request; held with its operands until `mem_ack`.
- `mem_rw` in `cache_rw`: `CACHE_READ` or `CACHE_WRITE`.
- `mem_funct3` in 3: access size and sign.
- `mem_addr` in ADDR_W: byte address.
- `mem_wdata` in DATA_W: store data, in the low lanes.
- `mem_ack` out 1: one-cycle response pulse.
- `mem_rdata` out DATA_W: extended load data; 0 for stores and faults.
- `mem_fault` out 1: qualifies `mem_ack`; set for a misaligned access or illegal `funct3`.
- `cache_req` out 1: held high from grant until the cycle after `cache_done`.
- `cache_rw` out `cache_rw`: read/write.
- `cache_op` out `cache_operation`: `CACHE_NOP` when idle.
- `cache_addr` out ADDR_W: byte address.
- `cache_wdata` out DATA_W: lane-replicated store data.
- `cache_rdata` in DATA_W: aligned word containing the addressed bytes.
- `cache_done` in 1: one-cycle completion pulse; ignored while `cache_req` = 0.

## Operation
- The state machine has four states:
  - `ARB_IDLE`: no transaction.
  - `ARB_IF_BUSY`: a fetch is outstanding on the cache.
  - `ARB_MEM_BUSY`: a load/store is outstanding on the cache.
  - `ARB_RESP`: one cycle; the granted requester's ack is asserted and new requests are ignored.
- In `ARB_IDLE`:
  - With one request pending, grant it.
  - With both pending, grant the one opposite to `last_grant`.
  - `last_grant` resets to IF, so the first tie goes to MEM.
  - On a grant, latch addr, rw, op and wdata into registers. `cache_*` outputs are driven only from these registers.
  - On a grant, update `last_grant`.
- A MEM grant checks legality first. It is a fault, and goes straight to `ARB_RESP` with no `cache_req`, if any of these hold:
  - LH/LHU/SH with `addr[0]` = 1.
  - LW/SW with `addr[1:0]` ≠ 0.
  - Load `funct3` ∈ {011, 110, 111}.
  - Store `funct3` ∉ {000, 001, 010}.
- `cache_op` mapping: B → `QUARTER_WORD`, H → `HALF_WORD`, W → `WORD`. IF accesses are always `WORD` + `CACHE_READ`.
- Store lanes: SB replicates `wdata[7:0]` ×4; SH replicates `wdata[15:0]` ×2; SW passes the word through.
- Load extraction:
  - LB/LBU take byte `addr[1:0]`.
  - LH/LHU take half `addr[1]`.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - LW takes the full word.
- Load data is captured from `cache_rdata` on the `cache_done` cycle.
- `if_rdata` and `mem_rdata` hold their last response value until the next ack for that port.
- Reset values: state `ARB_IDLE`, all acks 0, `mem_fault` 0, `cache_req` 0, `cache_op` `CACHE_NOP`, all data and address outputs 0.

## Timing
- Cycle 0: request seen in `ARB_IDLE`; grant decided.
- Cycle 1: `cache_req` = 1 from registers.
- Cycle N: `cache_done` = 1.
- Cycle N+1: `cache_req` = 0, `cache_op` = `CACHE_NOP`, ack = 1, state `ARB_RESP`.
- Cycle N+2: `ARB_IDLE`; requests are sampled again.
- Best case (`cache_done` in cycle 1): ack in cycle 2, next grant in cycle 3.
- Fault path: ack with `mem_fault` in cycle 1.
- A requester drops or changes its req in the cycle after it sees its ack. `ARB_RESP` guarantees the stale req is never re-granted.
- A request arriving while busy waits. The other requester is granted at least once between two grants to a continuously requesting port.
- Reset mid-transaction: back to `ARB_IDLE` next edge and the transaction is abandoned. The cache shares this reset.

## Structure
- Add to `rapid_pkg`:
  - `arb_state_t` (2-bit enum of the four states).
  - `arb_grant_t` { `GRANT_IF`, `GRANT_MEM` }.
  - Sized funct3 constants `3'b000`…`3'b101`. The block compares only against these sized binary constants.
- Sub-module `rapid_load_align`: combinational; inputs `funct3`, `addr[1:0]`, `rdata`; outputs the extended word. Also used by future uncached paths.
- The arbiter itself: FSM, latches, store replication, legality check.

## Test plan
- IF only, `if_addr`=0x0000_0103, `cache_done` in cycle 2 → `cache_addr`=0x100, `cache_op`=`WORD`, `if_ack` in cycle 3 with `if_rdata`=`cache_rdata`.
- Both request in the same cycle after reset → MEM granted first. Both still pending at the next `ARB_IDLE` → IF granted; the third tie goes to MEM.
- LB at 0x…02 with `cache_rdata`=0x0080_0000 → `mem_rdata`=0xFFFF_FF80. LBU gives 0x0000_0080. LHU at 0x…02 with `cache_rdata`=0x8001_0000 → 0x0000_8001.
- SB with `wdata`=0x1234_56AB → `cache_wdata`=0xABAB_ABAB, `cache_op`=`QUARTER_WORD`, `cache_rw`=`CACHE_WRITE`.
- LW at 0x…06 or load `funct3`=011 → `mem_ack` and `mem_fault` in cycle 1, `mem_rdata`=0, `cache_req` never asserted.
- Reset asserted in `ARB_MEM_BUSY` → next cycle `ARB_IDLE`, `cache_req`=0, no ack; a late `cache_done` is ignored.
